// File: rtl/bank_mem_ctrl.sv
// Four-bank 16-bit word memory: each bank is occupied for four cycles per access, and reads
// return through a two-stage pipeline. Define BANK_MEM_ALIGN_CHECK_EN to reject odd addresses.
module bank_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    logic [1:0]      bank;
    logic [IdxW-1:0] idx;
    logic            req;
    logic            err_raw;
    logic            accept;

    logic [3:0][1:0] cnt_q, cnt_d;
    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     s1_data_q;
    logic [15:0]     data_out_q, data_out_d;

    logic [15:0]     mem [MEM_WORDS];

    logic            unused_addr;

    // Upper address bits wrap; addr[0] only matters when the alignment check is built in.
    assign unused_addr = ^addr;

    assign bank = addr[2:1];
    assign idx  = addr[IdxW:1];
    assign req  = wr | rd;

    always_comb begin
        err_raw = wr & rd;
`ifdef BANK_MEM_ALIGN_CHECK_EN
        err_raw = err_raw | (req & addr[0]);
`endif
    end

    always_comb begin
        busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Combinational flags are masked while reset is held so nothing leaks out mid-reset.
    assign err    = err_raw & rst;
    assign stall  = req & busy[bank] & ~err_raw & rst;
    assign accept = (wr ^ rd) & ~err_raw & ~busy[bank] & rst;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && (bank == 2'(i))) begin
                cnt_d[i] = 2'd3;
            end else if (cnt_q[i] != 2'd0) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_comb begin
        s1_valid_d = accept & rd;
        data_out_d = 16'h0000;
        if (s1_valid_q) begin
            data_out_d = s1_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            data_out_q <= 16'h0000;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Array and its read register carry no reset; stage-1 data is qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[idx] <= data_in;
        end
        if (accept && rd) begin
            s1_data_q <= mem[idx];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_bank_mem_ctrl.sv
// Directed and randomized checks of bank_mem_ctrl against a cycle-indexed reference model
// (per-bank free-at cycle, sparse shadow array, queue of due read results).
module tb_bank_mem_ctrl;
    localparam int unsigned MemWords = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    always #5 clk = ~clk;

    bank_mem_ctrl #(.MEM_WORDS(MemWords)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    int checks = 0;
    int passed = 0;

    longint cyc = 0;
    longint free_at [4];
    logic [15:0] shadow [int unsigned];

    typedef struct {
        longint      due;
        logic [15:0] data;
        bit          known;
    } rd_t;
    rd_t pend [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One cycle: drive request, compare every output against the model, then advance the model.
    task automatic step(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d,
                        output bit acc, output bit stl);
        logic [1:0]  bnk;
        int unsigned idx;
        logic        e;
        logic [3:0]  b;
        logic [15:0] dexp;
        bit          dknown;
        @(negedge clk);
        wr = w;
        rd = r;
        addr = a;
        data_in = d;
        #1;
        bnk = a[2:1];
        idx = 32'(a[15:1]) % MemWords;
        e = w & r;
`ifdef BANK_MEM_ALIGN_CHECK_EN
        e = e | ((w | r) & a[0]);
`endif
        for (int i = 0; i < 4; i++) b[i] = (cyc < free_at[i]);
        stl = (w | r) & b[bnk] & ~e;
        acc = (w ^ r) & ~e & ~b[bnk];
        dexp = 16'h0000;
        dknown = 1'b1;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            dexp = pend[0].data;
            dknown = pend[0].known;
            void'(pend.pop_front());
        end
        check("err", 16'(err), 16'(e));
        check("stall", 16'(stall), 16'(stl));
        check("busy", 16'(busy), 16'(b));
        if (dknown) check("data_out", data_out, dexp);
        if (acc) begin
            free_at[bnk] = cyc + 4;
            if (r) begin
                pend.push_back('{cyc + 2, shadow.exists(idx) ? shadow[idx] : 16'h0000,
                                 shadow.exists(idx)});
            end
            if (w) shadow[idx] = d;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        bit stl;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, acc, stl);
    endtask

    // Retry a held request until accepted, within a cycle budget.
    task automatic issue(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
        bit acc;
        bit stl;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(w, r, a, d, acc, stl);
        if (!acc) check("issue_timeout", 16'(stall), 16'h0000);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        wr = 1'b1;
        rd = 1'b1;
        addr = 16'h0005;
        #1;
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_stall", 16'(stall), 16'h0000);
        check("rst_err", 16'(err), 16'h0000);
        repeat (n) @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        pend.delete();
        cyc += n + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        bit          stl;
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [15:0] d;
        int unsigned op;

        rst = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        addr = 16'h0000;
        data_in = 16'h0000;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        apply_reset(2);

        // Write then read the same word four cycles later.
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        idle(3);
        step(1'b0, 1'b1, 16'h0010, 16'h0000, acc, stl);
        check("t028_stall", 16'(stall), 16'h0000);
        idle(2);
        check("t028_data", data_out, 16'hBEEF);

        // Back-to-back reads across all four banks.
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 16'(2 * i), 16'(16'h1000 + i));
        idle(4);
        step(1'b0, 1'b1, 16'h0000, 16'h0000, acc, stl);
        step(1'b0, 1'b1, 16'h0002, 16'h0000, acc, stl);
        step(1'b0, 1'b1, 16'h0004, 16'h0000, acc, stl);
        check("t029_data0", data_out, 16'h1000);
        step(1'b0, 1'b1, 16'h0006, 16'h0000, acc, stl);
        check("t029_stall", 16'(stall), 16'h0000);
        check("t029_busy3", 16'(busy), 16'h0007);
        check("t029_data1", data_out, 16'h1001);
        idle(1);
        check("t029_busy4", 16'(busy), 16'h000E);
        check("t029_data2", data_out, 16'h1002);
        idle(1);
        check("t029_data3", data_out, 16'h1003);

        // Same-bank conflict: second read stalls three cycles.
        idle(4);
        issue(1'b1, 1'b0, 16'h0008, 16'hA5A5);
        issue(1'b1, 1'b0, 16'h0000, 16'h5A5A);
        idle(4);
        step(1'b0, 1'b1, 16'h0008, 16'h0000, acc, stl);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h0000, 16'h0000, acc, stl);
            check("t030_stall", 16'(stall), 16'h0001);
        end
        step(1'b0, 1'b1, 16'h0000, 16'h0000, acc, stl);
        check("t030_accept", 16'(stall), 16'h0000);
        idle(2);
        check("t030_data", data_out, 16'h5A5A);

        // Simultaneous wr and rd is an error and leaves the array alone.
        idle(4);
        issue(1'b1, 1'b0, 16'h0004, 16'h1234);
        idle(4);
        step(1'b1, 1'b1, 16'h0004, 16'hFFFF, acc, stl);
        check("t031_err", 16'(err), 16'h0001);
        check("t031_stall", 16'(stall), 16'h0000);
        step(1'b0, 1'b1, 16'h0004, 16'h0000, acc, stl);
        check("t031_busy", 16'(busy), 16'h0000);
        idle(2);
        check("t031_data", data_out, 16'h1234);

        // Address wrap: 0x2010 aliases 0x0010.
        idle(4);
        issue(1'b1, 1'b0, 16'h2010, 16'hC0DE);
        idle(4);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        idle(2);
        check("wrap_data", data_out, 16'hC0DE);

        // Reset with a read in flight: no pulse afterwards.
        idle(4);
        step(1'b0, 1'b1, 16'h0010, 16'h0000, acc, stl);
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("t032_no_pulse", data_out, 16'h0000);
        end

        // Misaligned address.
        issue(1'b1, 1'b0, 16'h0002, 16'h7777);
        idle(4);
        step(1'b0, 1'b1, 16'h0003, 16'h0000, acc, stl);
`ifdef BANK_MEM_ALIGN_CHECK_EN
        check("t032_misalign_err", 16'(err), 16'h0001);
        idle(2);
        check("t032_misalign_data", data_out, 16'h0000);
`else
        check("t032_misalign_err", 16'(err), 16'h0000);
        idle(2);
        check("t032_misalign_data", data_out, 16'h7777);
`endif

        // Randomized traffic; stalled requests are held unchanged.
        idle(4);
        w = 1'b0;
        r = 1'b0;
        a = 16'h0000;
        d = 16'h0000;
        stl = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!stl) begin
                op = $urandom_range(0, 9);
                w = (op < 4) || (op == 8);
                r = (op >= 4 && op < 8) || (op == 8);
                a = 16'(($urandom_range(0, 7) << 13) | ($urandom_range(0, 15) << 1)
                        | 32'($urandom_range(0, 7) == 0));
                d = 16'($urandom);
            end
            step(w, r, a, d, acc, stl);
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
